// File: rtl/phy_rx_pkg.sv
// Shared constants for the PHY receive frame detector: FSM encoding,
// preamble/SFD symbol values and a saturating 16-bit increment.
package phy_rx_pkg;

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] PREAMBLE = 2'd1;
   localparam logic [1:0] PAYLOAD  = 2'd2;
   localparam logic [1:0] DROP     = 2'd3;

   localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0] SFD_BYTE      = 8'hD5;
   localparam logic [3:0] PREAMBLE_NIB  = 4'h5;
   localparam logic [3:0] SFD_NIB       = 4'hD;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/phy_rx_nibble_pack.sv
// MII nibble-to-byte assembler: low nibble first, registered byte strobe.
// phase is high while a first nibble is held waiting for its partner.
module phy_rx_nibble_pack (
   input  logic       clock,
   input  logic       clear,
   input  logic       nib_valid,
   input  logic [3:0] nib,
   output logic [7:0] byte_data,
   output logic       byte_stb,
   output logic       phase
);

   logic [3:0] low_q, low_d;
   logic       phase_q, phase_d;
   logic [7:0] byte_q, byte_d;
   logic       stb_q, stb_d;

   // Hold the first nibble, emit {second, first} on the second one.
   always_comb begin
      low_d   = low_q;
      phase_d = phase_q;
      byte_d  = byte_q;
      stb_d   = 1'b0;
      if (nib_valid) begin
         if (phase_q) begin
            byte_d  = {nib, low_q};
            stb_d   = 1'b1;
            phase_d = 1'b0;
         end else begin
            low_d   = nib;
            phase_d = 1'b1;
         end
      end else begin
         stb_d = 1'b0;
      end
   end

   // Assembler state, cleared between frames.
   always_ff @(posedge clock) begin
      if (clear) begin
         low_q   <= 4'd0;
         phase_q <= 1'b0;
         byte_q  <= 8'd0;
         stb_q   <= 1'b0;
      end else begin
         low_q   <= low_d;
         phase_q <= phase_d;
         byte_q  <= byte_d;
         stb_q   <= stb_d;
      end
   end

   assign byte_data = byte_q;
   assign byte_stb  = stb_q;
   assign phase     = phase_q;

endmodule

// File: rtl/phy_rx_frame_det.sv
// Receive preamble/SFD detector delivering aligned payload bytes (GMII or MII).
// Optional frame statistics counters are enabled by defining PHY_RX_FRAME_STATS_EN.
module phy_rx_frame_det
   import phy_rx_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int MIN_PREAMBLE = 5,
   parameter int MAX_PREAMBLE = 7,
   parameter int LEN_WIDTH    = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] phy_rx_data,
   input  logic                  phy_rx_valid,
   input  logic                  phy_rx_error,
   output logic                  active,
   output logic [7:0]            rx_data,
   output logic                  rx_data_valid,
   output logic                  sof,
   output logic                  eof,
   output logic [LEN_WIDTH-1:0]  frame_len,
   output logic                  err_preamble,
   output logic                  err_rx,
   output logic [15:0]           good_frames,
   output logic [15:0]           bad_frames
);

   localparam int SPB      = (DATA_WIDTH == 4) ? 2 : 1;
   localparam int PRE_SAT  = (MAX_PREAMBLE + 1) * SPB;
   localparam int MIN_SYMS = MIN_PREAMBLE * SPB;
   localparam int CW       = $clog2(PRE_SAT + 1);
   localparam logic [DATA_WIDTH-1:0] PRE_SYM =
      (DATA_WIDTH == 4) ? DATA_WIDTH'(PREAMBLE_NIB) : DATA_WIDTH'(PREAMBLE_BYTE);
   localparam logic [DATA_WIDTH-1:0] SFD_SYM =
      (DATA_WIDTH == 4) ? DATA_WIDTH'(SFD_NIB) : DATA_WIDTH'(SFD_BYTE);

   logic [1:0]           state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [LEN_WIDTH-1:0] len_q, len_d;
   logic                 first_q, first_d;
   logic                 err_frame_q, err_frame_d;
   logic                 active_q, active_d;
   logic [7:0]           rx_data_q, rx_data_d;
   logic                 rx_valid_q, rx_valid_d;
   logic                 sof_q, sof_d;
   logic                 eof_q, eof_d;
   logic [LEN_WIDTH-1:0] frame_len_q, frame_len_d;
   logic                 err_pre_q, err_pre_d;
   logic                 err_rx_q, err_rx_d;
   logic                 drop_s;
   logic                 byte_evt_s;
   logic [7:0]           byte_val_s;
   logic                 odd_nib_s;

   generate
      if (DATA_WIDTH == 4) begin : g_nibble
         logic       pack_clr_s, pack_in_s, pack_stb_s, pack_phase_s;
         logic [7:0] pack_byte_s;
         assign pack_clr_s = reset || (state_q != PAYLOAD);
         assign pack_in_s  = (state_q == PAYLOAD) && phy_rx_valid;
         phy_rx_nibble_pack u_pack (
            .clock     (clock),
            .clear     (pack_clr_s),
            .nib_valid (pack_in_s),
            .nib       (phy_rx_data[3:0]),
            .byte_data (pack_byte_s),
            .byte_stb  (pack_stb_s),
            .phase     (pack_phase_s)
         );
         // The strobe for the final pair may land on the valid-fall cycle.
         assign byte_evt_s = (state_q == PAYLOAD) && pack_stb_s;
         assign byte_val_s = pack_byte_s;
         assign odd_nib_s  = pack_phase_s;
      end else begin : g_byte
         assign byte_evt_s = (state_q == PAYLOAD) && phy_rx_valid;
         assign byte_val_s = 8'(phy_rx_data);
         assign odd_nib_s  = 1'b0;
      end
   endgenerate

   // Frame FSM, preamble count, payload delivery and error tracking.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      len_d       = len_q;
      first_d     = first_q;
      err_frame_d = err_frame_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = 1'b0;
      sof_d       = 1'b0;
      eof_d       = 1'b0;
      frame_len_d = frame_len_q;
      err_pre_d   = 1'b0;
      err_rx_d    = err_rx_q;
      drop_s      = 1'b0;
      case (state_q)
         IDLE: begin
            if (!phy_rx_valid) begin
               state_d = IDLE;
            end else if (phy_rx_data == PRE_SYM) begin
               state_d = PREAMBLE;
               cnt_d   = CW'(1);
            end else begin
               state_d = DROP;
               drop_s  = 1'b1;
            end
         end
         PREAMBLE: begin
            if (!phy_rx_valid) begin
               state_d = IDLE;
            end else if (phy_rx_error) begin
               state_d = DROP;
               drop_s  = 1'b1;
            end else if (phy_rx_data == PRE_SYM) begin
               cnt_d = (cnt_q >= CW'(PRE_SAT)) ? cnt_q : cnt_q + CW'(1);
            end else if ((phy_rx_data == SFD_SYM) && (cnt_q >= CW'(MIN_SYMS))) begin
               state_d     = PAYLOAD;
               err_pre_d   = (cnt_q >= CW'(PRE_SAT));
               len_d       = '0;
               first_d     = 1'b1;
               err_frame_d = 1'b0;
            end else begin
               state_d = DROP;
               drop_s  = 1'b1;
            end
         end
         PAYLOAD: begin
            if (phy_rx_valid) begin
               err_frame_d = err_frame_q | phy_rx_error;
            end else begin
               state_d     = IDLE;
               eof_d       = 1'b1;
               err_frame_d = err_frame_q | odd_nib_s;
            end
         end
         DROP: begin
            if (!phy_rx_valid) begin
               state_d = IDLE;
            end else begin
               state_d = DROP;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (byte_evt_s) begin
         rx_data_d  = byte_val_s;
         rx_valid_d = 1'b1;
         sof_d      = first_q;
         first_d    = 1'b0;
         len_d      = (&len_q) ? len_q : len_q + LEN_WIDTH'(1);
      end else begin
         rx_valid_d = 1'b0;
      end

      if (eof_d) begin
         frame_len_d = len_d;
      end else begin
         frame_len_d = frame_len_q;
      end

      // err_rx keeps the previous frame's status until the new frame's sof.
      if (sof_d || eof_d || ((state_q == PAYLOAD) && !first_q)) begin
         err_rx_d = err_frame_d;
      end else begin
         err_rx_d = err_rx_q;
      end
   end

   assign active_d = (state_d == PAYLOAD);

   // State and output registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         len_q       <= '0;
         first_q     <= 1'b0;
         err_frame_q <= 1'b0;
         active_q    <= 1'b0;
         rx_data_q   <= 8'd0;
         rx_valid_q  <= 1'b0;
         sof_q       <= 1'b0;
         eof_q       <= 1'b0;
         frame_len_q <= '0;
         err_pre_q   <= 1'b0;
         err_rx_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         len_q       <= len_d;
         first_q     <= first_d;
         err_frame_q <= err_frame_d;
         active_q    <= active_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         sof_q       <= sof_d;
         eof_q       <= eof_d;
         frame_len_q <= frame_len_d;
         err_pre_q   <= err_pre_d;
         err_rx_q    <= err_rx_d;
      end
   end

`ifdef PHY_RX_FRAME_STATS_EN
   logic [15:0] good_q, bad_q;

   // Frame statistics; a dropped frame counts as bad on entry to DROP.
   always_ff @(posedge clock) begin
      if (reset) begin
         good_q <= 16'd0;
         bad_q  <= 16'd0;
      end else begin
         if (eof_d && !err_frame_d) begin
            good_q <= sat_inc16(good_q);
         end else begin
            good_q <= good_q;
         end
         if ((eof_d && err_frame_d) || drop_s) begin
            bad_q <= sat_inc16(bad_q);
         end else begin
            bad_q <= bad_q;
         end
      end
   end

   assign good_frames = good_q;
   assign bad_frames  = bad_q;
`else
   assign good_frames = 16'd0;
   assign bad_frames  = 16'd0;
`endif

   assign active        = active_q;
   assign rx_data       = rx_data_q;
   assign rx_data_valid = rx_valid_q;
   assign sof           = sof_q;
   assign eof           = eof_q;
   assign frame_len     = frame_len_q;
   assign err_preamble  = err_pre_q;
   assign err_rx        = err_rx_q;

endmodule

// File: tb/tb_phy_rx_frame_det.sv
// Scoreboard bench for phy_rx_frame_det: a GMII instance and an MII instance
// (4-bit frame_len to reach saturation), directed plus random frames.
`timescale 1ns/1ps
module tb_phy_rx_frame_det;

   localparam int MIN_P  = 5;
   localparam int MAX_P  = 7;
   localparam int K_EP   = 0;
   localparam int K_BYTE = 1;
   localparam int K_EOF  = 2;

   typedef struct {
      int kind;
      int data;
      bit sof;
      int len;
      bit err;
   } ev_t;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic        reset;
   logic [7:0]  d0;
   logic        v0, e0;
   logic [3:0]  d1;
   logic        v1, e1;
   logic        act0, rv0, sof0, eof0, ep0, er0;
   logic [7:0]  rd0;
   logic [15:0] fl0, gf0, bf0;
   logic        act1, rv1, sof1, eof1, ep1, er1;
   logic [7:0]  rd1;
   logic [3:0]  fl1;
   logic [15:0] gf1, bf1;

   phy_rx_frame_det #(.DATA_WIDTH(8), .MIN_PREAMBLE(MIN_P), .MAX_PREAMBLE(MAX_P), .LEN_WIDTH(16)) dut0 (
      .clock(clock), .reset(reset), .phy_rx_data(d0), .phy_rx_valid(v0), .phy_rx_error(e0),
      .active(act0), .rx_data(rd0), .rx_data_valid(rv0), .sof(sof0), .eof(eof0),
      .frame_len(fl0), .err_preamble(ep0), .err_rx(er0), .good_frames(gf0), .bad_frames(bf0));

   phy_rx_frame_det #(.DATA_WIDTH(4), .MIN_PREAMBLE(MIN_P), .MAX_PREAMBLE(MAX_P), .LEN_WIDTH(4)) dut1 (
      .clock(clock), .reset(reset), .phy_rx_data(d1), .phy_rx_valid(v1), .phy_rx_error(e1),
      .active(act1), .rx_data(rd1), .rx_data_valid(rv1), .sof(sof1), .eof(eof1),
      .frame_len(fl1), .err_preamble(ep1), .err_rx(er1), .good_frames(gf1), .bad_frames(bf1));

   ev_t exq[2][$];
   int  checks = 0;
   int  errors = 0;
   int  good_m[2];
   int  bad_m[2];
   int  act_m[2];
   int  act_seen[2];
   int  pay[$];

   task automatic chk(input string nm, input int inst, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s dut%0d got %0d expected %0d", nm, inst, got, exp);
      end
   endtask

   function automatic int front_kind(input int i);
      if (exq[i].size() == 0) return -1;
      return exq[i][0].kind;
   endfunction

   task automatic mon(input int i, input logic act, input logic rv, input logic [7:0] rd,
                      input logic sf, input logic ef, input int fl, input logic ep, input logic er);
      ev_t e;
      if (act === 1'b1) act_seen[i]++;
      if (ep === 1'b1) begin
         chk("err_preamble_event", i, K_EP, front_kind(i));
         if (front_kind(i) == K_EP) e = exq[i].pop_front();
      end
      if (rv === 1'b1) begin
         chk("byte_event", i, K_BYTE, front_kind(i));
         if (front_kind(i) == K_BYTE) begin
            e = exq[i].pop_front();
            chk("rx_data", i, int'(rd), e.data);
            chk("sof", i, int'(sf), int'(e.sof));
            if (i == 0 && e.sof) begin
               chk("err_rx_at_sof", i, int'(er), int'(e.err));
               chk("active_at_sof", i, int'(act), 1);
            end
         end
      end else if (sf === 1'b1) begin
         chk("sof_without_valid", i, int'(sf), 0);
      end
      if (ef === 1'b1) begin
         chk("eof_event", i, K_EOF, front_kind(i));
         if (front_kind(i) == K_EOF) begin
            e = exq[i].pop_front();
            chk("frame_len", i, fl, e.len);
            chk("err_rx_at_eof", i, int'(er), int'(e.err));
         end
      end
   endtask

   // Monitor: compares every DUT output event against the expected queues.
   always @(negedge clock) begin
      mon(0, act0, rv0, rd0, sof0, eof0, int'(fl0), ep0, er0);
      mon(1, act1, rv1, rd1, sof1, eof1, int'(fl1), ep1, er1);
   end

   task automatic drive(input int i, input int sym, input bit err, input bit vld);
      if (i == 0) begin
         d0 = 8'(sym); v0 = vld; e0 = err;
      end else begin
         d1 = 4'(sym); v1 = vld; e1 = err;
      end
      @(posedge clock);
      #1;
   endtask

   // One frame: npre preamble symbols, SFD (or a wrong symbol), then pay[].
   // pre_err: symbol index (1..npre) flagged with RX_ER, -1 none.
   // pay_err: payload symbol index flagged with RX_ER, -1 none.
   task automatic send_frame(input int i, input int npre, input bit sfd_ok,
                             input int pre_err, input int pay_err, input int gap);
      int  spb     = (i == 0) ? 1 : 2;
      int  sym_pre = (i == 0) ? 'h55 : 'h5;
      int  sym_sfd = (i == 0) ? 'hD5 : 'hD;
      int  mask    = (i == 0) ? 255 : 15;
      int  lenmax  = (i == 0) ? 65535 : 15;
      int  syms[$];
      int  other;
      int  nbytes;
      bit  accept;
      bit  ferr;
      ev_t e;
      for (int k = 0; k < npre; k++) syms.push_back(sym_pre);
      if (sfd_ok) begin
         syms.push_back(sym_sfd);
      end else begin
         other = sym_pre;
         while (other == sym_pre || other == sym_sfd) other = int'($urandom) & mask;
         syms.push_back(other);
      end
      foreach (pay[k]) syms.push_back(pay[k]);

      accept = sfd_ok && ((npre / spb) >= MIN_P) && !(pre_err >= 1 && pre_err <= npre);
      if (!accept) begin
         bad_m[i]++;
      end else begin
         if ((npre / spb) > MAX_P) begin
            e = '{kind: K_EP, data: 0, sof: 1'b0, len: 0, err: 1'b0};
            exq[i].push_back(e);
         end
         nbytes = pay.size() / spb;
         for (int b = 0; b < nbytes; b++) begin
            e.kind = K_BYTE;
            e.data = (i == 0) ? pay[b] : ((pay[2*b+1] << 4) | pay[2*b]);
            e.sof  = (b == 0);
            e.len  = 0;
            e.err  = (pay_err == 0);
            exq[i].push_back(e);
         end
         ferr = (pay_err >= 0) || ((pay.size() % spb) != 0);
         e = '{kind: K_EOF, data: 0, sof: 1'b0, len: (nbytes > lenmax) ? lenmax : nbytes, err: ferr};
         exq[i].push_back(e);
         if (ferr) bad_m[i]++;
         else good_m[i]++;
         act_m[i] += pay.size() + 1;
      end

      foreach (syms[k]) begin
         drive(i, syms[k], (k == pre_err) || (pay_err >= 0 && k == npre + 1 + pay_err), 1'b1);
      end
      for (int g = 0; g < gap; g++) drive(i, 0, 1'b0, 1'b0);
   endtask

   task automatic chk_stats();
`ifdef PHY_RX_FRAME_STATS_EN
      chk("good_frames", 0, int'(gf0), good_m[0]);
      chk("bad_frames", 0, int'(bf0), bad_m[0]);
      chk("good_frames", 1, int'(gf1), good_m[1]);
      chk("bad_frames", 1, int'(bf1), bad_m[1]);
`else
      chk("good_frames", 0, int'(gf0), 0);
      chk("bad_frames", 0, int'(bf0), 0);
      chk("good_frames", 1, int'(gf1), 0);
      chk("bad_frames", 1, int'(bf1), 0);
`endif
   endtask

   task automatic chk_reset_vals(input int i);
      if (i == 0) begin
         chk("rst_active", 0, int'(act0), 0);
         chk("rst_rx_data_valid", 0, int'(rv0), 0);
         chk("rst_sof_eof", 0, int'({sof0, eof0}), 0);
         chk("rst_errs", 0, int'({ep0, er0}), 0);
         chk("rst_rx_data", 0, int'(rd0), 0);
         chk("rst_frame_len", 0, int'(fl0), 0);
      end else begin
         chk("rst_active", 1, int'(act1), 0);
         chk("rst_rx_data_valid", 1, int'(rv1), 0);
         chk("rst_sof_eof", 1, int'({sof1, eof1}), 0);
         chk("rst_errs", 1, int'({ep1, er1}), 0);
         chk("rst_rx_data", 1, int'(rd1), 0);
         chk("rst_frame_len", 1, int'(fl1), 0);
      end
   endtask

   task automatic rand_frame(input int i);
      int spb  = (i == 0) ? 1 : 2;
      int mask = (i == 0) ? 255 : 15;
      int npre, len, pre_err, pay_err;
      bit sfd_ok;
      npre    = $urandom_range(0, (MAX_P + 3) * spb);
      sfd_ok  = ($urandom_range(0, 99) < 85);
      pre_err = (npre > 0 && $urandom_range(0, 9) == 0) ? $urandom_range(1, npre) : -1;
      len     = (i == 0) ? $urandom_range(0, 20) : $urandom_range(0, 41);
      pay.delete();
      for (int k = 0; k < len; k++) pay.push_back(int'($urandom) & mask);
      pay_err = (len > 0 && $urandom_range(0, 6) == 0) ? $urandom_range(0, len - 1) : -1;
      send_frame(i, npre, sfd_ok, pre_err, pay_err, $urandom_range(1, 3));
   endtask

   initial begin
      ev_t e;
      for (int i = 0; i < 2; i++) begin
         good_m[i] = 0; bad_m[i] = 0; act_m[i] = 0; act_seen[i] = 0;
      end
      reset = 1'b1;
      d0 = 8'd0; v0 = 1'b0; e0 = 1'b0;
      d1 = 4'd0; v1 = 1'b0; e1 = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      chk_reset_vals(0);
      chk_reset_vals(1);
      chk_stats();
      reset = 1'b0;
      drive(0, 0, 1'b0, 1'b0);

      // Plan 1: nominal 64-byte frame.
      pay.delete();
      for (int k = 1; k <= 64; k++) pay.push_back(k);
      send_frame(0, 7, 1'b1, -1, -1, 2);
      // Plan 2: preamble too short.
      pay.delete();
      for (int k = 0; k < 6; k++) pay.push_back(k + 'h30);
      send_frame(0, 4, 1'b1, -1, -1, 2);
      chk_stats();
      // Plan 3: overlong preamble, frame still accepted.
      pay.delete();
      for (int k = 0; k < 10; k++) pay.push_back(k + 'h80);
      send_frame(0, 9, 1'b1, -1, -1, 1);
      // Plan 5: RX_ER on payload byte 3, then a clean frame back-to-back.
      pay.delete();
      for (int k = 0; k < 8; k++) pay.push_back(k + 'hA0);
      send_frame(0, 7, 1'b1, -1, 2, 1);
      send_frame(0, 7, 1'b1, -1, -1, 2);
      chk_stats();
      // Plan 4: MII nibble frame.
      pay.delete();
      pay.push_back('hA); pay.push_back('hB); pay.push_back('hC); pay.push_back('hD);
      send_frame(1, 14, 1'b1, -1, -1, 2);
      chk_stats();

      for (int n = 0; n < 40; n++) rand_frame(0);
      for (int n = 0; n < 40; n++) rand_frame(1);
      repeat (4) drive(0, 0, 1'b0, 1'b0);
      chk_stats();

      // Plan 6: reset while payload byte 5 is on the wire.
      for (int k = 0; k < 7; k++) drive(0, 'h55, 1'b0, 1'b1);
      drive(0, 'hD5, 1'b0, 1'b1);
      for (int b = 1; b <= 4; b++) begin
         e = '{kind: K_BYTE, data: b, sof: (b == 1), len: 0, err: 1'b0};
         exq[0].push_back(e);
      end
      act_m[0] += 5;
      for (int b = 1; b <= 4; b++) drive(0, b, 1'b0, 1'b1);
      d0 = 8'd5; v0 = 1'b1; reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0; v0 = 1'b0; d0 = 8'd0;
      for (int i = 0; i < 2; i++) begin
         good_m[i] = 0; bad_m[i] = 0;
      end
      chk_reset_vals(0);
      chk_stats();
      chk("queue_after_reset", 0, exq[0].size(), 0);
      drive(0, 0, 1'b0, 1'b0);
      pay.delete();
      for (int k = 0; k < 6; k++) pay.push_back(k + 'h10);
      send_frame(0, 7, 1'b1, -1, -1, 3);
      chk_stats();

      repeat (5) drive(0, 0, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) begin
         chk("pending_events", i, exq[i].size(), 0);
         chk("active_cycles", i, act_seen[i], act_m[i]);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/phy_rx_frame_det.md
Name: phy_rx_frame_det

Overview:
Parametrised successor to the HPSDR receive-side preamble detector. It accepts raw PHY receive symbols, either GMII bytes or MII nibbles, and detects a preamble of configurable length followed by the SFD. It then delivers aligned payload bytes with start/end-of-frame strobes, a frame length and error indications. It sits between the PHY interface and the MAC receive parser.

Parameters:
DATA_WIDTH, 8, PHY symbol width; 8 = GMII byte mode, 4 = MII nibble mode (low nibble first); any other value is illegal.
MIN_PREAMBLE, 5, minimum count of 0x55 bytes (byte equivalents) required before the SFD.
MAX_PREAMBLE, 7, more than this many preamble bytes raises err_preamble; the frame is still accepted.
LEN_WIDTH, 16, width of frame_len; the counter saturates.

Ports:
clock  in  1  receive clock; all signals are sampled at posedge.
reset  in  1  synchronous, active-high.
phy_rx_data  in  DATA_WIDTH  PHY receive symbol.
phy_rx_valid  in  1  RX_DV.
phy_rx_error  in  1  RX_ER.
active  out  1  high while payload is being delivered (same meaning as the predecessor).
rx_data  out  8  assembled payload byte.
rx_data_valid  out  1  rx_data is valid this cycle.
sof  out  1  one-cycle pulse, coincident with rx_data_valid of the first payload byte.
eof  out  1  one-cycle pulse, the cycle after phy_rx_valid falls during PAYLOAD.
frame_len  out  LEN_WIDTH  payload byte count, updated on the eof cycle.
err_preamble  out  1  one-cycle pulse at SFD acceptance when the preamble exceeded MAX_PREAMBLE.
err_rx  out  1  sticky per frame; set when phy_rx_error is seen in PAYLOAD, cleared at the next sof.
good_frames  out  16  see Optional Feature.
bad_frames  out  16  see Optional Feature.

Behaviour:
- Reset: state=IDLE; active, rx_data_valid, sof, eof, err_preamble, err_rx = 0; rx_data=0; frame_len=0; counters=0.
- Preamble is counted in symbols:
  - Byte mode: symbol 0x55, SFD 0xD5.
  - Nibble mode: symbol 0x5, SFD nibble 0xD. Two nibbles make one byte equivalent.
  - The preamble counter saturates at MAX_PREAMBLE+1 bytes.
- States:
  - IDLE: on phy_rx_valid with preamble symbol → PREAMBLE, count=1 symbol. On valid with any other symbol → DROP.
  - PREAMBLE:
    - preamble symbol → count++ (saturating).
    - SFD with count ≥ MIN_PREAMBLE bytes → PAYLOAD; pulse err_preamble if count > MAX_PREAMBLE.
    - SFD with count too short, or any other symbol → DROP.
    - phy_rx_valid low → IDLE.
  - PAYLOAD: active=phy_rx_valid.
    - Byte mode: rx_data=phy_rx_data, rx_data_valid=1, with one-cycle latency from input.
    - Nibble mode: the first nibble is held in the low half and the second nibble completes the byte {second, first}. rx_data_valid pulses once per two nibbles, one cycle after the second nibble.
    - The frame-length counter increments per byte and saturates at all-ones.
    - phy_rx_valid low → eof pulse, frame_len latched, → IDLE.
    - Odd trailing nibble at valid fall: discarded; err_rx set before eof.
  - DROP: ignores data until phy_rx_valid falls → IDLE. No sof/eof is generated.
- phy_rx_error in PREAMBLE → DROP. phy_rx_error in PAYLOAD → err_rx set; payload delivery continues.
- phy_rx_valid re-asserted the cycle immediately after a fall: eof for the old frame and IDLE processing of the new symbol occur in the same cycle.
- Reset mid-frame: immediate return to IDLE. No eof is emitted and counters are not incremented.

Optional Feature:
Macro PHY_RX_FRAME_STATS_EN.
- Defined: good_frames increments at eof when err_rx=0. bad_frames increments at eof when err_rx=1, and on each entry to DROP. Both are 16-bit saturating and cleared only by reset.
- Undefined: both outputs are tied to 0 and no counter logic is synthesised.

Decomposition:
- Shared package phy_rx_pkg:
  - state encoding localparams: IDLE, PREAMBLE, PAYLOAD, DROP.
  - PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5, PREAMBLE_NIB=4'h5, SFD_NIB=4'hD.
- Sub-module phy_rx_nibble_pack: nibble-to-byte assembler with a phase bit and byte strobe. Instantiated only when DATA_WIDTH==4 (generate).

Test Plan:
1. Byte mode, 7×0x55, 0xD5, payload 0x01..0x40 (64 bytes), then valid low → sof with rx_data=0x01, 64 rx_data_valid strobes, eof, frame_len=64, no errors.
2. Byte mode, 4×0x55 then 0xD5 (MIN=5) → DROP; no sof/active. With stats enabled, bad_frames=1.
3. Byte mode, 9×0x55, 0xD5, 10 bytes → err_preamble pulse at SFD acceptance, sof, frame_len=10.
4. Nibble mode, 14×0x5, 0xD, nibbles 0xA,0xB,0xC,0xD → rx_data 0xBA then 0xDC, sof on 0xBA, eof, frame_len=2.
5. Byte mode, phy_rx_error high on payload byte 3 of 8 → err_rx=1 at eof, frame_len=8. Next clean frame → err_rx cleared at its sof; stats good=1, bad=1.
6. Reset asserted at payload byte 5 → outputs return to reset values next cycle, no eof. A following 7×0x55+0xD5 frame is received normally.
